// File: rtl/wavelet_bank_scheduler.sv
// Sample-strobe divider plus round-robin scheduler that serialises a bank of FIR results onto one valid/ready port.
// Latency: capture edge then grant edge (o_valid two cycles after i_fir_valid); throughput one word per two cycles.
module wavelet_bank_scheduler #(
    parameter int NUM_FILTERS = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int SAMPLE_DIV  = 4,
    localparam int IW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_enable,
    output logic                              o_sample_en,
    input  logic [NUM_FILTERS-1:0]            i_fir_valid,
    input  logic [NUM_FILTERS*DATA_WIDTH-1:0] i_fir_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic [IW-1:0]                     o_index,
    output logic [NUM_FILTERS-1:0]            o_overrun,
    input  logic                              i_clear_overrun
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);

    localparam logic [0:0] SCAN = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [CW-1:0]          div_cnt;
    logic [0:0]             state;
    logic [IW-1:0]          rr_ptr;
    logic [NUM_FILTERS-1:0] pending;
    logic [DATA_WIDTH-1:0]  holding [NUM_FILTERS];

    logic                   sel_found;
    logic [IW-1:0]          sel_idx;
    logic                   grant;
    logic [NUM_FILTERS-1:0] grant_vec;
    logic [NUM_FILTERS-1:0] ovr_evt;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NUM_FILTERS) s = s - NUM_FILTERS;
        return IW'(s);
    endfunction

    // Strobe is combinational so it lands in the same cycle the count reaches its last value.
    assign o_sample_en = !reset && i_enable && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (i_enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (!sel_found && pending[wrap_add(rr_ptr, i)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(rr_ptr, i);
            end
        end
    end

    assign grant     = (state == SCAN) && sel_found;
    assign grant_vec = grant ? (NUM_FILTERS'(1) << sel_idx) : '0;
    // A capture landing on the index being granted this edge refills an emptied slot, not an overrun.
    assign ovr_evt   = i_fir_valid & pending & ~grant_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            o_overrun <= '0;
            for (int k = 0; k < NUM_FILTERS; k++) holding[k] <= '0;
        end else begin
            pending   <= (pending & ~grant_vec) | i_fir_valid;
            o_overrun <= (i_clear_overrun ? '0 : o_overrun) | ovr_evt;
            for (int k = 0; k < NUM_FILTERS; k++) begin
                if (i_fir_valid[k]) holding[k] <= i_fir_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= SCAN;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_index <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (sel_found) begin
                        o_data  <= holding[sel_idx];
                        o_index <= sel_idx;
                        o_valid <= 1'b1;
                        rr_ptr  <= wrap_add(sel_idx, 1);
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= SCAN;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    state   <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: doc/wavelet_bank_scheduler.md
WAVELET_BANK_SCHEDULER -- requirements
Module: wavelet_bank_scheduler

Interface
REQ-001 Parameter NUM_FILTERS, default 8: number of FIR filter outputs in the bank.
REQ-002 Parameter DATA_WIDTH, default 16: width of each filter result word.
REQ-003 Parameter SAMPLE_DIV, default 4: clock cycles per sample strobe; legal range 2..2^16.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port i_enable  input  1: 1 = sample-strobe divider runs; 0 = divider holds its count.
REQ-007 Port o_sample_en  output  1: one-cycle strobe that advances the tap shift line.
REQ-008 Port i_fir_valid  input  NUM_FILTERS: bit k high for one cycle = filter k result present.
REQ-009 Port i_fir_data  input  NUM_FILTERS*DATA_WIDTH: filter k result at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port o_valid  output  1: output word valid.
REQ-011 Port i_ready  input  1: downstream accepts the word when o_valid and i_ready are both high.
REQ-012 Port o_data  output  DATA_WIDTH: granted filter result.
REQ-013 Port o_index  output  clog2(NUM_FILTERS): index of the granted filter, min width 1.
REQ-014 Port o_overrun  output  NUM_FILTERS: sticky per-filter overrun flags.
REQ-015 Port i_clear_overrun  input  1: clears all o_overrun bits.

Function
REQ-016 Divider counts 0..SAMPLE_DIV-1 while i_enable=1 and wraps to 0; o_sample_en is high exactly in cycles where count=SAMPLE_DIV-1 and i_enable=1.
REQ-017 With i_enable=1 continuously from reset release, o_sample_en is first high in the SAMPLE_DIV-th cycle, then every SAMPLE_DIV cycles.
REQ-018 i_enable=0 freezes the count and forces o_sample_en=0; counting resumes from the held value.
REQ-019 Each filter has a DATA_WIDTH holding register and a pending bit; i_fir_valid[k]=1 loads holding[k] from slice k and sets pending[k] on the next edge.
REQ-020 Capture while pending[k] is already set overwrites holding[k], keeps pending[k]=1 and sets o_overrun[k]=1.
REQ-021 o_overrun bits clear only on reset or i_clear_overrun=1; a simultaneous new overrun event wins, leaving that bit set.
REQ-022 FSM states: SCAN and HOLD.
REQ-023 SCAN: if any pending bit is set, select the first pending index at or after rr_ptr, wrapping modulo NUM_FILTERS; on the next edge load o_data/o_index, clear that pending bit, set o_valid=1, set rr_ptr=(index+1) mod NUM_FILTERS and go to HOLD; otherwise stay in SCAN with o_valid=0.
REQ-024 HOLD: o_valid=1 and o_data/o_index stay stable until i_ready=1; on that edge go to SCAN and o_valid=0 next cycle.
REQ-025 Maximum throughput is one word per 2 cycles; latency from i_fir_valid to o_valid is at least 2 cycles (capture, then grant).
REQ-026 Capture and grant of the same index on the same edge: the grant takes the old holding value and the capture re-sets pending with the new value, with no overrun.
REQ-027 Captures during HOLD are unaffected by the output stall; only the holding registers and pending bits change.
REQ-028 Round-robin fairness: with all filters continuously pending, every index is granted once per NUM_FILTERS grants.

Reset
REQ-029 On reset: divider count=0, o_sample_en=0, all pending=0, holding registers=0, o_valid=0, o_data=0, o_index=0, o_overrun=0, rr_ptr=0, FSM=SCAN.
REQ-030 Reset in HOLD drops the word in flight with no acceptance; all inputs are ignored during the reset cycle.

Verification
REQ-031 reset released, i_enable=1, SAMPLE_DIV=4 -> o_sample_en high in cycles 4, 8, 12; with i_enable=0 in cycles 5-6, the next pulse moves from cycle 8 to cycle 10.
REQ-032 i_fir_valid=8'h01, data0=16'h1234, i_ready=1 -> two cycles later o_valid=1, o_data=16'h1234, o_index=0 for one cycle.
REQ-033 i_fir_valid=8'hFF once, i_ready=1 -> indices 0..7 output in order, one every 2 cycles; set i_fir_valid=8'h81 afterwards with rr_ptr=0 -> order 0, 7.
REQ-034 i_ready=0 for 10 cycles, i_fir_valid[3] pulsed twice (0x0AAA then 0x0BBB) -> o_overrun[3]=1; after i_ready=1 the grant for index 3 carries 0x0BBB; i_clear_overrun -> o_overrun=0.
REQ-035 reset asserted while in HOLD with o_valid=1 -> next cycle o_valid=0, all pending=0, rr_ptr=0.
REQ-036 Filter 2 granted and i_fir_valid[2] pulsed on the same edge -> old value output, new value output on the following grant, o_overrun[2]=0.
